// File: rtl/tone_player.sv
// tone_player: square-wave note player; each command sets divider, duration (ms) and volume.
// Defining TONE_PLAYER_GAP_EN inserts GAP_MS of silence after every note.
module tone_player #(
  parameter int CLK_HZ = 100000000,
  parameter int DIV_W  = 17,
  parameter int DUR_W  = 10,
  parameter int VOL_W  = 3,
  parameter int GAP_MS = 10
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic [VOL_W-1:0] cmd_vol,
  output logic             wave,
  output logic             speaker_out,
  output logic             tone_active
);

  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int PRE_W  = $clog2(MS_CYC);
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(MS_CYC - 1);
  // The duty counter has 2^VOL_W-1 states so that full volume passes the wave unchanged.
  localparam logic [VOL_W-1:0] PWM_LAST = VOL_W'((1 << VOL_W) - 2);

  generate
    if (MS_CYC < 2 || (CLK_HZ % 1000) != 0 || GAP_MS < 0) begin : g_param_check
      $error("tone_player: CLK_HZ/1000 must be an integer >= 2 and GAP_MS >= 0");
    end
  endgenerate

`ifdef TONE_PLAYER_GAP_EN
  localparam int GAP_CYC = GAP_MS * MS_CYC;
  localparam int GAP_W   = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  logic [GAP_W-1:0] gap_reg, gap_next;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;
`endif

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [VOL_W-1:0] vol_reg, vol_next;
  logic [DIV_W-1:0] half_reg, half_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [DUR_W-1:0] dur_reg, dur_next;
  logic             wave_reg, wave_next;
  logic [VOL_W-1:0] pwm_reg, pwm_next;
  logic             spk_reg, spk_next;
  logic             accept;

  assign cmd_ready   = (state_reg == S_IDLE) && !reset;
  assign accept      = cmd_valid && cmd_ready;
  assign tone_active = (state_reg == S_PLAY) && (div_reg != '0);
  assign wave        = wave_reg;
  assign speaker_out = spk_reg;

  // Attenuation path runs independently of the note FSM.
  always_comb begin
    pwm_next = (pwm_reg == PWM_LAST) ? '0 : pwm_reg + VOL_W'(1);
    spk_next = wave_reg && (pwm_reg < vol_reg);
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    vol_next   = vol_reg;
    half_next  = half_reg;
    pre_next   = pre_reg;
    dur_next   = dur_reg;
    wave_next  = wave_reg;
`ifdef TONE_PLAYER_GAP_EN
    gap_next   = gap_reg;
`endif
    unique case (state_reg)
      S_IDLE: begin
        wave_next = 1'b0;
        if (accept) begin
          div_next  = cmd_div;
          vol_next  = cmd_vol;
          dur_next  = cmd_dur;
          pre_next  = PRE_LOAD;
          half_next = cmd_div - DIV_W'(1);
          if (cmd_dur != '0) begin
            state_next = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        if (half_reg == '0) begin
          half_next = div_reg - DIV_W'(1);
          if (div_reg != '0) begin
            wave_next = ~wave_reg;
          end
        end else begin
          half_next = half_reg - DIV_W'(1);
        end

        if (pre_reg == '0) begin
          pre_next = PRE_LOAD;
          dur_next = dur_reg - DUR_W'(1);
          if (dur_reg == DUR_W'(1)) begin
            wave_next = 1'b0;
`ifdef TONE_PLAYER_GAP_EN
            if (GAP_CYC > 0) begin
              state_next = S_GAP;
              gap_next   = GAP_LOAD;
            end else begin
              state_next = S_IDLE;
            end
`else
            state_next = S_IDLE;
`endif
          end
        end else begin
          pre_next = pre_reg - PRE_W'(1);
        end
      end

`ifdef TONE_PLAYER_GAP_EN
      S_GAP: begin
        wave_next = 1'b0;
        if (gap_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
`endif

      default: begin
        state_next = S_IDLE;
        wave_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg <= S_IDLE;
      div_reg   <= '0;
      vol_reg   <= '0;
      half_reg  <= '0;
      pre_reg   <= '0;
      dur_reg   <= '0;
      wave_reg  <= 1'b0;
      pwm_reg   <= '0;
      spk_reg   <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
      gap_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      vol_reg   <= vol_next;
      half_reg  <= half_next;
      pre_reg   <= pre_next;
      dur_reg   <= dur_next;
      wave_reg  <= wave_next;
      pwm_reg   <= pwm_next;
      spk_reg   <= spk_next;
`ifdef TONE_PLAYER_GAP_EN
      gap_reg   <= gap_next;
`endif
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed and random notes checked cycle by cycle against a timeline model
// derived from note duration, divider and a free-running 7-state duty counter.
module tb_tone_player;

  localparam int CLK_HZ = 8000;
  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int DIV_W  = 17;
  localparam int DUR_W  = 10;
  localparam int VOL_W  = 3;
  localparam int GAP_MS = 2;
`ifdef TONE_PLAYER_GAP_EN
  localparam int GAP_CYC = GAP_MS * MS_CYC;
`else
  localparam int GAP_CYC = 0;
`endif
  localparam int PWM_STATES = (1 << VOL_W) - 1;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIV_W-1:0] cmd_div;
  logic [DUR_W-1:0] cmd_dur;
  logic [VOL_W-1:0] cmd_vol;
  logic             wave;
  logic             speaker_out;
  logic             tone_active;

  int   checks;
  int   errors;
  int   cyc;
  int   pwm_now;
  int   pwm_prev;
  logic wave_prev;

  tone_player #(
    .CLK_HZ(CLK_HZ),
    .DIV_W (DIV_W),
    .DUR_W (DUR_W),
    .VOL_W (VOL_W),
    .GAP_MS(GAP_MS)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_div    (cmd_div),
    .cmd_dur    (cmd_dur),
    .cmd_vol    (cmd_vol),
    .wave       (wave),
    .speaker_out(speaker_out),
    .tone_active(tone_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock and track the duty counter value before and after the edge.
  task automatic step();
    @(posedge clk);
    pwm_prev = pwm_now;
    if (reset) pwm_now = 0;
    else       pwm_now = (pwm_now + 1) % PWM_STATES;
    cyc++;
    #1;
  endtask

  task automatic cycle_check(input logic exp_wave, input logic exp_tone,
                             input logic exp_ready, input int vol);
    logic exp_spk;
    exp_spk = wave_prev && (pwm_prev < vol);
    chk("wave", wave, exp_wave);
    chk("speaker_out", speaker_out, exp_spk);
    chk("tone_active", tone_active, exp_tone);
    chk("cmd_ready", cmd_ready, exp_ready);
    wave_prev = exp_wave;
  endtask

  task automatic idle(input int n, input int vol);
    for (int i = 0; i < n; i++) begin
      step();
      cycle_check(1'b0, 1'b0, 1'b1, vol);
    end
  endtask

  // One note: wave after the k-th edge past acceptance is floor(k/div) mod 2 while playing.
  task automatic play_note(input int div, input int dur, input int vol, input bit keep_valid);
    int   n;
    int   gap;
    int   waited;
    logic exp_play;
    logic exp_wave;
    n      = dur * MS_CYC;
    gap    = (dur > 0) ? GAP_CYC : 0;
    waited = 0;
    while (!cmd_ready && waited < 100) begin
      step();
      wave_prev = 1'b0;
      waited++;
    end
    chk("ready_before_accept", cmd_ready, 1'b1);
    cmd_div   = DIV_W'(div);
    cmd_dur   = DUR_W'(dur);
    cmd_vol   = VOL_W'(vol);
    cmd_valid = 1'b1;
    $display("note div=%0d dur=%0d vol=%0d hold=%0d at cyc=%0d", div, dur, vol, keep_valid, cyc);
    for (int k = 0; k <= n + gap; k++) begin
      step();
      if (k == 0 && !keep_valid) cmd_valid = 1'b0;
      exp_play = (k < n);
      exp_wave = (exp_play && div != 0) ? (((k / (div == 0 ? 1 : div)) % 2) == 1) : 1'b0;
      cycle_check(exp_wave, exp_play && (div != 0), (k >= n + gap), vol);
    end
  endtask

  initial begin
    int d, u, v, h;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    pwm_now   = 0;
    pwm_prev  = 0;
    wave_prev = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_div   = '0;
    cmd_dur   = '0;
    cmd_vol   = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_wave", wave, 1'b0);
      chk("rst_speaker", speaker_out, 1'b0);
      chk("rst_tone", tone_active, 1'b0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_wave", wave, 1'b0);
    chk("post_rst_tone", tone_active, 1'b0);
    idle(2, 0);

    play_note(3, 2, 7, 1'b0);
    play_note(0, 1, 5, 1'b0);
    play_note(5, 0, 7, 1'b0);
    idle(3, 7);
    play_note(2, 4, 3, 1'b0);
    play_note(4, 2, 0, 1'b0);
    play_note(1, 1, 6, 1'b0);
    play_note(3, 1, 6, 1'b1);
    play_note(3, 1, 6, 1'b0);
    idle(2, 6);

    // Reset in the 5th PLAY cycle with a new command already held.
    cmd_div   = DIV_W'(4);
    cmd_dur   = DUR_W'(3);
    cmd_vol   = VOL_W'(7);
    cmd_valid = 1'b1;
    $display("note div=4 dur=3 vol=7 interrupted by reset at cyc=%0d", cyc);
    for (int k = 0; k < 5; k++) begin
      step();
      cycle_check(((k / 4) % 2) == 1, 1'b1, 1'b0, 7);
    end
    reset   = 1'b1;
    cmd_div = DIV_W'(2);
    cmd_dur = DUR_W'(1);
    cmd_vol = VOL_W'(7);
    step();
    wave_prev = 1'b0;
    chk("midrst_wave", wave, 1'b0);
    chk("midrst_tone", tone_active, 1'b0);
    chk("midrst_speaker", speaker_out, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_release_ready", cmd_ready, 1'b1);
    play_note(2, 1, 7, 1'b0);

    for (int r = 0; r < 14; r++) begin
      d = $urandom_range(0, 6);
      u = $urandom_range(0, 3);
      v = $urandom_range(0, 7);
      h = $urandom_range(0, 1);
      play_note(d, u, v, h[0]);
    end
    cmd_valid = 1'b0;
    idle(3, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
